forloop_generate_checker_02: RTL

- Receive-side checker for the per-bit alternating register pattern, where bit j is expected to equal j%2.
- For WIDTH=32 the golden word is 32'hAAAA_AAAA.
- Samples a WIDTH-bit bus under a valid strobe and compares each bit in a generate loop.
- Keeps per-bit sticky error flags, a saturating word-error counter and a lock state machine.
- Sits at the output of the pattern-driven register bank in self-test configurations.

---
 rtl/forloop_generate_checker_02.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/forloop_generate_checker_02.sv
// Receive-side checker for the alternating per-bit pattern (bit j == j%2).
// Optional macro FORLOOP_GENERATE_CHECKER_INV_EN also accepts the inverted pattern.
module forloop_generate_checker_02 #(
    parameter int WIDTH    = 32,
    parameter int LOCK_CNT = 4,
    parameter int ERRW     = 16
) (
    input  logic             c,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic             clr,
    output logic             match,
    output logic             locked,
    output logic [WIDTH-1:0] err_bits,
    output logic [ERRW-1:0]  err_cnt
);

    localparam int SW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    // Handshake: d is consumed on a rising edge of c only when d_valid is high;
    // there is no backpressure, so every valid word is checked exactly once.

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    logic [WIDTH-1:0] exp_pat;
    logic [WIDTH-1:0] m_e;
    logic [WIDTH-1:0] m;
    logic             hit;

    state_t           state_q, state_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic [SW-1:0]    streak_inc;
    logic             match_q, match_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

    for (genvar j = 0; j < WIDTH; j++) begin : g_exp
        assign exp_pat[j] = ((j % 2) == 1);
    end

    assign m_e = d ^ exp_pat;

`ifdef FORLOOP_GENERATE_CHECKER_INV_EN
    // Compare against whichever polarity is closer; ties stay on the true pattern.
    int ones_e;
    always_comb begin
        ones_e = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_e = ones_e + int'(m_e[i]);
        end
        m = ((WIDTH - ones_e) < ones_e) ? ~m_e : m_e;
    end
`else
    assign m = m_e;
`endif

    assign hit        = (m == '0);
    assign streak_inc = streak_q + SW'(1);

    // FSM state register
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state_q  <= SEARCH;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        if (d_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (!hit) begin
                        streak_d = '0;
                    end else if (streak_inc == SW'(LOCK_CNT)) begin
                        state_d  = LOCKED;
                        streak_d = '0;
                    end else begin
                        streak_d = streak_inc;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        state_d  = SEARCH;
                        streak_d = '0;
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    streak_d = '0;
                end
            endcase
        end
    end

    // FSM output logic
    always_comb begin
        locked = (state_q == LOCKED);
    end

    // Error statistics: clr discards any error contribution of the same cycle.
    always_comb begin
        match_d    = match_q;
        err_bits_d = err_bits_q;
        err_cnt_d  = err_cnt_q;
        if (d_valid) begin
            match_d = hit;
            if (!hit) begin
                err_bits_d = err_bits_q | m;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERRW'(1);
                end
            end
        end
        if (clr) begin
            err_bits_d = '0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            match_q    <= 1'b0;
            err_bits_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            match_q    <= match_d;
            err_bits_q <= err_bits_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign match    = match_q;
    assign err_bits = err_bits_q;
    assign err_cnt  = err_cnt_q;

endmodule
